// File: rtl/ae350_reset_sequencer.sv
// AE350 power-up / reset sequencer.
// Qualifies PLL lock, releases DDR3 reset, waits for calibration (with timeout),
// then releases the SoC reset domains one after another. Lock loss or a
// debounced key press restarts the whole sequence from the beginning.
module ae350_reset_sequencer #(
    parameter int NUM_DOMAINS        = 4,
    parameter int LOCK_STABLE_CYCLES = 8,
    parameter int STAGGER_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int INIT_TIMEOUT       = 4096
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   PLL_LOCK,
    input  logic                   DDR3_INIT,
    input  logic                   KEY_RSTN,
    output logic                   DDR3_RSTN,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RSTN,
    output logic                   SEQ_DONE,
    output logic                   SEQ_ERROR,
    output logic [2:0]             STATE,
    output logic [7:0]             LOCK_LOST_CNT
);

    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W    = $clog2(INIT_TIMEOUT + 1);
    localparam int STAG_W   = $clog2(STAGGER_CYCLES + 1);
    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_DDR_RST   = 3'd1,
        S_STAGGER   = 3'd2,
        S_RUN       = 3'd3,
        S_ERROR     = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [1:0]            lock_sync, init_sync, key_sync;
    logic                  lock_s, init_s, key_s;
    logic [DEB_W-1:0]      deb_cnt;
    logic                  press, lock_lost;
    logic [STABLE_W-1:0]   stable_cnt, stable_nx;
    logic [TMO_W-1:0]      tmo_cnt, tmo_nx;
    logic [STAG_W-1:0]     stag_cnt, stag_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic                  ddr_nx, done_nx, err_nx;
    logic [NUM_DOMAINS-1:0] dom_nx;
    logic [7:0]            lost_nx;

    assign lock_s = lock_sync[1];
    assign init_s = init_sync[1];
    assign key_s  = key_sync[1];
    assign STATE  = state;

    // Two-flop synchronisers; the key idles high so it resets to 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_sync <= 2'b00;
            init_sync <= 2'b00;
            key_sync  <= 2'b11;
        end else begin
            lock_sync <= {lock_sync[0], PLL_LOCK};
            init_sync <= {init_sync[0], DDR3_INIT};
            key_sync  <= {key_sync[0], KEY_RSTN};
        end
    end

    // Saturating low-time counter; the key has to go high again to re-arm.
    always_ff @(posedge CLK) begin
        if (RST || key_s)
            deb_cnt <= '0;
        else if (deb_cnt != DEB_W'(DEBOUNCE_CYCLES))
            deb_cnt <= deb_cnt + DEB_W'(1);
    end

    // Press fires on the edge where the count reaches its target.
    assign press     = !key_s && (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign lock_lost = !lock_s && (state == S_DDR_RST || state == S_STAGGER || state == S_RUN);

    // State register and registered outputs, all updated together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_WAIT_LOCK;
            DDR3_RSTN     <= 1'b0;
            DOMAIN_RSTN   <= '0;
            SEQ_DONE      <= 1'b0;
            SEQ_ERROR     <= 1'b0;
            LOCK_LOST_CNT <= 8'd0;
            stable_cnt    <= '0;
            tmo_cnt       <= '0;
            stag_cnt      <= '0;
            idx           <= '0;
        end else begin
            state         <= state_nx;
            DDR3_RSTN     <= ddr_nx;
            DOMAIN_RSTN   <= dom_nx;
            SEQ_DONE      <= done_nx;
            SEQ_ERROR     <= err_nx;
            LOCK_LOST_CNT <= lost_nx;
            stable_cnt    <= stable_nx;
            tmo_cnt       <= tmo_nx;
            stag_cnt      <= stag_nx;
            idx           <= idx_nx;
        end
    end

    // Next state and next output values; aborts take priority over progress.
    always_comb begin
        state_nx  = state;
        ddr_nx    = DDR3_RSTN;
        dom_nx    = DOMAIN_RSTN;
        done_nx   = SEQ_DONE;
        err_nx    = SEQ_ERROR;
        lost_nx   = LOCK_LOST_CNT;
        stable_nx = stable_cnt;
        tmo_nx    = tmo_cnt;
        stag_nx   = stag_cnt;
        idx_nx    = idx;

        if (press || lock_lost) begin
            // Restart from scratch with every reset asserted.
            state_nx  = S_WAIT_LOCK;
            ddr_nx    = 1'b0;
            dom_nx    = '0;
            done_nx   = 1'b0;
            err_nx    = 1'b0;
            stable_nx = '0;
            tmo_nx    = '0;
            stag_nx   = '0;
            idx_nx    = '0;
            if (!press && LOCK_LOST_CNT != 8'hFF)
                lost_nx = LOCK_LOST_CNT + 8'd1;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    ddr_nx  = 1'b0;
                    dom_nx  = '0;
                    done_nx = 1'b0;
                    err_nx  = 1'b0;
                    if (!lock_s) begin
                        stable_nx = '0;
                    end else if (stable_cnt == STABLE_W'(LOCK_STABLE_CYCLES)) begin
                        // Lock has been stable for the full qualification window.
                        state_nx  = S_DDR_RST;
                        ddr_nx    = 1'b1;
                        stable_nx = '0;
                        tmo_nx    = '0;
                    end else begin
                        stable_nx = stable_cnt + STABLE_W'(1);
                    end
                end
                S_DDR_RST: begin
                    if (init_s) begin
                        dom_nx[0] = 1'b1;
                        tmo_nx    = '0;
                        stag_nx   = '0;
                        idx_nx    = IDX_W'(1);
                        if (NUM_DOMAINS == 1) begin
                            state_nx = S_RUN;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = S_STAGGER;
                        end
                    end else if (tmo_cnt == TMO_W'(INIT_TIMEOUT - 1)) begin
                        state_nx = S_ERROR;
                        err_nx   = 1'b1;
                        ddr_nx   = 1'b0;
                        tmo_nx   = '0;
                    end else begin
                        tmo_nx = tmo_cnt + TMO_W'(1);
                    end
                end
                S_STAGGER: begin
                    // stag_cnt measures the gap since the previous release.
                    if (stag_cnt == STAG_W'(STAGGER_CYCLES - 1)) begin
                        stag_nx     = '0;
                        dom_nx[idx] = 1'b1;
                        idx_nx      = idx + IDX_W'(1);
                        if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
                            state_nx = S_RUN;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        stag_nx = stag_cnt + STAG_W'(1);
                    end
                end
                default: ; // RUN and ERROR hold until an abort
            endcase
        end
    end

endmodule

// File: tb/tb_ae350_reset_sequencer.sv
// Bench for ae350_reset_sequencer: directed timing scenarios plus random
// stimulus, all checked cycle by cycle against a phase/timestamp model.
module tb_ae350_reset_sequencer;

    localparam int N    = 4;
    localparam int LOCK = 8;
    localparam int STAG = 16;
    localparam int DEB  = 16;
    localparam int TMO  = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_lock = 1'b0;
    logic         ddr3_init = 1'b0;
    logic         key_rstn = 1'b1;
    logic         ddr3_rstn;
    logic [N-1:0] dom;
    logic         done, err;
    logic [2:0]   state;
    logic [7:0]   lost_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ae350_reset_sequencer #(
        .NUM_DOMAINS(N), .LOCK_STABLE_CYCLES(LOCK), .STAGGER_CYCLES(STAG),
        .DEBOUNCE_CYCLES(DEB), .INIT_TIMEOUT(TMO)
    ) dut (
        .CLK(clk), .RST(rst), .PLL_LOCK(pll_lock), .DDR3_INIT(ddr3_init),
        .KEY_RSTN(key_rstn), .DDR3_RSTN(ddr3_rstn), .DOMAIN_RSTN(dom),
        .SEQ_DONE(done), .SEQ_ERROR(err), .STATE(state), .LOCK_LOST_CNT(lost_cnt)
    );

    // Reference model: phase number, edge of phase entry, run lengths.
    int cyc = 0, ph = 0, t_ent = 0, lock_run = 0, key_run = 0, m_lost = 0;
    bit l1 = 0, l2 = 0, i1 = 0, i2 = 0, k1 = 1, k2 = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit ls, is_, ks, press;
        cyc++;
        ls = l2; is_ = i2; ks = k2;
        l2 = l1; l1 = pll_lock;
        i2 = i1; i1 = ddr3_init;
        k2 = k1; k1 = key_rstn;
        if (rst) begin
            l1 = 0; l2 = 0; i1 = 0; i2 = 0; k1 = 1; k2 = 1;
            ph = 0; t_ent = cyc; lock_run = 0; key_run = 0; m_lost = 0;
            return;
        end
        key_run = ks ? 0 : key_run + 1;
        press = !ks && (key_run == DEB);
        if (press) begin
            ph = 0; lock_run = 0;
        end else if (!ls && ph >= 1 && ph <= 3) begin
            ph = 0; lock_run = 0;
            if (m_lost < 255) m_lost++;
        end else begin
            case (ph)
                0: begin
                    lock_run = ls ? lock_run + 1 : 0;
                    // release after LOCK fully-stable cycles have been counted
                    if (lock_run > LOCK) begin ph = 1; t_ent = cyc; lock_run = 0; end
                end
                1: begin
                    if (is_) begin ph = (N == 1) ? 3 : 2; t_ent = cyc; end
                    else if (cyc - t_ent == TMO) ph = 4;
                end
                2: if (1 + (cyc - t_ent) / STAG >= N) ph = 3;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic [N-1:0] dm = '0;
        logic dd = 0, dn = 0, er = 0;
        int k;
        case (ph)
            1: dd = 1;
            2: begin dd = 1; k = 1 + (cyc - t_ent) / STAG; dm = N'((1 << k) - 1); end
            3: begin dd = 1; dm = '1; dn = 1; end
            4: er = 1;
            default: ;
        endcase
        return 32'({3'(ph), dd, dm, dn, er, 8'(m_lost)});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({state, ddr3_rstn, dom, done, err, lost_cnt});
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("cycle", dut_vec(), exp_vec());
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:          return ddr3_rstn;
            1, 2, 3, 4: return dom[sel-1];
            5:          return done;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int limit, input string tag);
        int n = 0;
        while (sig(sel) !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(sig(sel)), 32'd1);
    endtask

    // Boot from WAIT_LOCK; with full=0 return right after domain 0 is released.
    task automatic boot(input bit full);
        int t0, ti;
        pll_lock = 0; ddr3_init = 0;
        tick(4);
        pll_lock = 1; t0 = cyc + 1;
        wait_until(0, 100, "lock_wait");
        chk("lock_to_ddr", 32'(cyc - t0), 32'd10);
        tick(19);
        ddr3_init = 1; ti = cyc + 1;
        wait_until(1, 100, "init_wait");
        chk("init_to_dom0", 32'(cyc - ti), 32'd2);
        if (full) begin
            for (int i = 1; i < N; i++) begin
                wait_until(i + 1, 100, "stag_wait");
                chk("dom_step", 32'(cyc - ti), 32'(2 + STAG * i));
            end
            chk("boot_done", 32'(done), 32'd1);
            chk("boot_state", 32'(state), 32'd3);
        end
    endtask

    initial begin
        int khold;
        tick(3);
        chk("reset_vec", dut_vec(), 32'd0);
        rst = 0;

        // Clean boot
        boot(1);

        // Lock loss in RUN, then re-lock
        pll_lock = 0;
        tick(2);
        chk("loss_pre_state", 32'(state), 32'd3);
        tick(1);
        chk("loss_dom", 32'(dom), 32'd0);
        chk("loss_ddr", 32'(ddr3_rstn), 32'd0);
        chk("loss_state", 32'(state), 32'd0);
        chk("loss_cnt", 32'(lost_cnt), 32'd1);
        ddr3_init = 0;
        tick(5);
        boot(1);

        // Short key pulse ignored; long one restarts at T+17
        key_rstn = 0; tick(10); key_rstn = 1; tick(6);
        chk("short_key_state", 32'(state), 32'd3);
        chk("short_key_done", 32'(done), 32'd1);
        key_rstn = 0;
        tick(17);
        chk("key_t16_state", 32'(state), 32'd3);
        tick(1);
        chk("key_t17_state", 32'(state), 32'd0);
        chk("key_t17_dom", 32'(dom), 32'd0);
        chk("key_cnt_same", 32'(lost_cnt), 32'd1);
        ddr3_init = 0;
        tick(3);
        key_rstn = 1;

        // DDR3 init timeout
        wait_until(0, 100, "ddr_entry");
        tick(63);
        chk("tmo_t63_state", 32'(state), 32'd1);
        tick(1);
        chk("tmo_state", 32'(state), 32'd4);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_ddr", 32'(ddr3_rstn), 32'd0);
        pll_lock = 0; tick(6);
        chk("err_sticky", 32'(state), 32'd4);
        chk("err_cnt_same", 32'(lost_cnt), 32'd1);
        pll_lock = 1;
        key_rstn = 0;
        tick(17);
        chk("err_key_t16", 32'(state), 32'd4);
        tick(1);
        chk("err_key_state", 32'(state), 32'd0);
        chk("err_key_err", 32'(err), 32'd0);
        tick(3);
        key_rstn = 1;
        boot(1);

        // Press and lock loss on the same edge while staggering
        key_rstn = 0; ddr3_init = 0; tick(20); key_rstn = 1; tick(2);
        boot(0);
        key_rstn = 0;
        tick(15);
        pll_lock = 0;
        tick(2);
        chk("both_pre_state", 32'(state), 32'd2);
        tick(1);
        chk("both_state", 32'(state), 32'd0);
        chk("both_cnt", 32'(lost_cnt), 32'd1);
        tick(3);
        key_rstn = 1;
        tick(2);

        // Counter saturation
        ddr3_init = 1;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1;
            wait_until(5, 200, "relock_done");
            tick($urandom_range(0, 5));
            pll_lock = 0;
            tick($urandom_range(3, 8));
        end
        chk("sat_cnt", 32'(lost_cnt), 32'd255);

        // RST mid-stagger
        boot(0);
        wait_until(2, 100, "dom1_wait");
        tick(3);
        rst = 1;
        tick(1);
        chk("midrst_vec", dut_vec(), 32'd0);
        chk("midrst_cnt", 32'(lost_cnt), 32'd0);
        rst = 0;
        tick(2);

        // Random traffic
        khold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) pll_lock = ~pll_lock;
            if ($urandom_range(0, 59) == 0) ddr3_init = ~ddr3_init;
            if (khold == 0) begin
                key_rstn = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
                khold = $urandom_range(3, 30);
            end else begin
                khold--;
            end
            rst = ($urandom_range(0, 799) == 0);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
